gauss3x3_filter: RTL and testbench
==================================

// Module: gauss3x3_filter
// PURPOSE
//   Downstream neighbour of the grayscale stage. Consumes its raster-order 8-bit gray pixel
//   stream (valid-qualified, no backpressure) and applies a 3x3 Gaussian blur using two
//   WIDTH-deep line buffers plus a 3x3 window. Emits only interior pixels, (WIDTH-2)x(HEIGHT-2),
//   to the next memory stage. Signals frame completion to the controller.
// PARAMETERS
//   WIDTH   64  image width in pixels (>=3)
//   HEIGHT  64  image height in pixels (>=3)
// PORTS
//   clk        in   1   clock
//   rst_n      in   1   asynchronous active-low reset
//   enable     in   1   from controller; level, frame active while high
//   in_valid   in   1   pix_in carries a pixel this cycle
//   pix_in     in   8   gray pixel, raster order
//   out_valid  out  1   pix_out valid this cycle (single-cycle strobe per output pixel)
//   pix_out    out  8   filtered pixel
//   busy       out  1   high in RUN
//   done       out  1   one-cycle pulse after the last input pixel of the frame
// BEHAVIOUR
//   - Reset: state=IDLE; out_valid=0, pix_out=8'h00, busy=0, done=0; row/col counters=0;
//     window regs=0. Line-buffer contents are don't-care.
//   - FSM: IDLE --enable--> RUN; RUN --accepted pixel at (HEIGHT-1, WIDTH-1)--> DONE;
//     DONE --(1 cycle)--> IDLE. In RUN, enable=0 -> IDLE next cycle, counters cleared,
//     no done, partial frame discarded. DONE->IDLE is unconditional; a new frame needs
//     enable seen in IDLE (re-arms immediately if enable is still high).
//   - in_valid is ignored in IDLE and DONE.
//   - In RUN, each in_valid: write pix_in to the line buffer at col, shift the 3x3 window with
//     column {lb1[col], lb0[col], pix_in}, then advance col. col wraps WIDTH-1 -> 0 and
//     increments row. in_valid gaps of any length are allowed; state holds.
//   - Output rule: if the accepted pixel has row>=2 and col>=2, then out_valid=1 exactly one
//     cycle later. pix_out is the filtered value centred at (row-1, col-1). Otherwise out_valid=0.
//   - Window must hold the 3x3 neighbourhood for that centre. Window contents from
//     wrap-around columns (col<2) never produce output.
//   - Kernel [1 2 1; 2 4 2; 1 2 1]. Sum is 12-bit unsigned (max 4080), no overflow.
//     pix_out = sum>>4 (truncate). Result is <=255 by construction, no saturation needed.
//   - pix_out holds its last value when out_valid=0.
//   - busy=1 iff state==RUN. done=1 iff state==DONE.
//   - Last output strobe coincides with the done cycle.
//   - Total strobes per complete frame = (WIDTH-2)*(HEIGHT-2), e.g. 3844 for 64x64.
//   - Async reset mid-frame: immediate return to reset values, no done.
// CONFIGURATION
//   GAUSS_ROUND_EN defined:   pix_out = (sum + 8) >> 4 (round-half-up). Sum widened to 13 bits
//                             internally; max (4080+8)>>4 = 255, still no saturation.
//   GAUSS_ROUND_EN undefined: truncating sum>>4. No adder present.
// TESTING
//   1. 64x64, all pixels 100, in_valid every cycle -> 3844 strobes, all pix_out=100;
//      done one cycle after the 4096th input.
//   2. 5x5 zeros with 255 at (2,2), truncating build -> centre (2,2)=63; edge-adjacent (1,2),
//      (2,1), (2,3), (3,2)=31; corners (1,1), (1,3), (3,1), (3,3)=15; 9 strobes total.
//   3. Same impulse, GAUSS_ROUND_EN build -> 64 / 32 / 16 respectively.
//   4. 4x4 ramp pix=col*10, in_valid toggling 1,0,1,0 -> 4 strobes, each exactly one cycle
//      after its triggering input; values 10,20,10,20 in raster order.
//   5. Drop enable after 20 inputs of a 64x64 frame -> IDLE next cycle, no done.
//      A full frame then restarted -> exactly 3844 strobes, correct values.
//   6. Assert rst_n=0 mid-frame with in_valid=1 -> outputs zero immediately;
//      in_valid while in IDLE -> no strobes.

Source files
------------

// File: rtl/gauss3x3_filter_if.sv
// Pixel stream and status bundle between the controller/grayscale stage and gauss3x3_filter.
interface gauss3x3_filter_if;
    logic       enable;
    logic       in_valid;
    logic [7:0] pix_in;
    logic       out_valid;
    logic [7:0] pix_out;
    logic       busy;
    logic       done;

    modport master (
        output enable, in_valid, pix_in,
        input  out_valid, pix_out, busy, done
    );

    modport slave (
        input  enable, in_valid, pix_in,
        output out_valid, pix_out, busy, done
    );
endinterface

// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian blur [1 2 1; 2 4 2; 1 2 1]/16 over a raster gray stream; emits interior pixels only.
// Define GAUSS_ROUND_EN for round-half-up output instead of truncation.
module gauss3x3_filter #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64
) (
    input logic              clk,
    input logic              rst_n,
    gauss3x3_filter_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          accept;
    logic          last_px;

    logic [7:0]    lb0 [WIDTH];
    logic [7:0]    lb1 [WIDTH];
    logic [7:0]    win  [3][3];
    logic [7:0]    nwin [3][3];
    logic [7:0]    ncol [3];
    logic [11:0]   sum;
    logic [7:0]    pix_next;
`ifdef GAUSS_ROUND_EN
    logic [12:0]   sum_r;
`endif

    assign accept  = (state_q == S_RUN) && bus.enable && bus.in_valid;
    assign last_px = (row_q == RW'(HEIGHT-1)) && (col_q == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.enable) state_d = S_RUN;
            S_RUN: begin
                if (!bus.enable)            state_d = S_IDLE;
                else if (accept && last_px) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == CW'(WIDTH-1)) begin
                col_q <= '0;
                row_q <= last_px ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end else if (state_q == S_RUN && !bus.enable) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

    // Line buffers carry no reset so they can map onto RAM; stale data only feeds suppressed outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_q] <= bus.pix_in;
            lb1[col_q] <= lb0[col_q];
        end
    end

    always_comb begin
        ncol[0] = lb1[col_q];
        ncol[1] = lb0[col_q];
        ncol[2] = bus.pix_in;
        for (int unsigned r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
            nwin[r][2] = ncol[r];
        end
    end

    // The filter runs on the post-shift window so the result registers on the accepting edge.
    always_comb begin
        sum = 12'(nwin[0][0]) + 12'(nwin[0][2]) + 12'(nwin[2][0]) + 12'(nwin[2][2])
            + ((12'(nwin[0][1]) + 12'(nwin[1][0]) + 12'(nwin[1][2]) + 12'(nwin[2][1])) << 1)
            + (12'(nwin[1][1]) << 2);
`ifdef GAUSS_ROUND_EN
        sum_r    = 13'(sum) + 13'd8;
        pix_next = 8'(sum_r >> 4);
`else
        pix_next = 8'(sum >> 4);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else if (accept) begin
            win <= nwin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.pix_out   <= '0;
        end else begin
            bus.out_valid <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (accept && (row_q >= RW'(2)) && (col_q >= CW'(2)))
                bus.pix_out <= pix_next;
        end
    end
endmodule

// File: tb/tb_gauss3x3_filter.sv
// Self-checking bench: 64x64, 5x5 and 4x4 instances share the pixel stream, each with its own enable.
module tb_gauss3x3_filter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gauss3x3_filter_if if0 ();
    gauss3x3_filter_if if1 ();
    gauss3x3_filter_if if2 ();

    gauss3x3_filter #(.WIDTH(64), .HEIGHT(64)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gauss3x3_filter #(.WIDTH(5),  .HEIGHT(5))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    gauss3x3_filter #(.WIDTH(4),  .HEIGHT(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic       en [3];
    logic       vin;
    logic [7:0] pin;
    logic       ov [3];
    logic [7:0] po [3];
    logic       bz [3];
    logic       dn [3];

    assign if0.enable = en[0]; assign if0.in_valid = vin; assign if0.pix_in = pin;
    assign if1.enable = en[1]; assign if1.in_valid = vin; assign if1.pix_in = pin;
    assign if2.enable = en[2]; assign if2.in_valid = vin; assign if2.pix_in = pin;
    assign ov[0] = if0.out_valid; assign po[0] = if0.pix_out; assign bz[0] = if0.busy; assign dn[0] = if0.done;
    assign ov[1] = if1.out_valid; assign po[1] = if1.pix_out; assign bz[1] = if1.busy; assign dn[1] = if1.done;
    assign ov[2] = if2.out_valid; assign po[2] = if2.pix_out; assign bz[2] = if2.busy; assign dn[2] = if2.done;

    // Reference model state
    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
    int         mw [3] = '{64, 5, 4};
    int         mh [3] = '{64, 5, 4};
    mst_t       mst [3];
    int         mrow [3];
    int         mcol [3];
    bit         expv [3];
    logic [7:0] img [3][64][64];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] last [3];
    logic [7:0] cap [3][16];
    int         ncap [3];
    int         strobes [3];
    logic [7:0] e_pix;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        int r;
        int c;
        int exp_t;
        int exp_r;
    } vec_t;
    vec_t imp_tab [9];
    vec_t ramp_tab [4];

    task automatic check(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    endtask

    function automatic logic [7:0] ref_pix(input int k, input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(img[k][r+dr][c+dc]) * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
`ifdef GAUSS_ROUND_EN
        s += 8;
`endif
        return 8'(s >> 4);
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int k, input logic [7:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            expv[k] = 1'b0;
            case (mst[k])
                M_IDLE: if (en[k]) mst[k] = M_RUN;
                M_RUN: begin
                    if (!en[k]) begin
                        mst[k] = M_IDLE; mrow[k] = 0; mcol[k] = 0;
                    end else if (vin) begin
                        img[k][mrow[k]][mcol[k]] = pin;
                        if (mrow[k] >= 2 && mcol[k] >= 2) begin
                            expv[k] = 1'b1;
                            push(k, ref_pix(k, mrow[k]-1, mcol[k]-1));
                        end
                        if (mcol[k] == mw[k]-1) begin
                            mcol[k] = 0;
                            if (mrow[k] == mh[k]-1) begin
                                mrow[k] = 0; mst[k] = M_DONE;
                            end else mrow[k]++;
                        end else mcol[k]++;
                    end
                end
                default: mst[k] = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input bit v, input logic [7:0] p);
        vin = v;
        pin = p;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_out_valid", k, ov[k], 0);
            check("rst_pix_out",   k, po[k], 0);
            check("rst_busy",      k, bz[k], 0);
            check("rst_done",      k, dn[k], 0);
            mst[k] = M_IDLE; mrow[k] = 0; mcol[k] = 0; expv[k] = 1'b0;
            last[k] = 8'h00; en[k] = 1'b0;
        end
        q0.delete(); q1.delete(); q2.delete();
        vin = 1'b0;
        pin = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 3; k++) begin
                check("busy",      k, bz[k], mst[k] == M_RUN);
                check("done",      k, dn[k], mst[k] == M_DONE);
                check("out_valid", k, ov[k], expv[k]);
                if (ov[k]) begin
                    strobes[k]++;
                    if (qsize(k) == 0) begin
                        check("scoreboard_underflow", k, 1, 0);
                    end else begin
                        case (k)
                            0:       e_pix = q0.pop_front();
                            1:       e_pix = q1.pop_front();
                            default: e_pix = q2.pop_front();
                        endcase
                        check("pix_out", k, po[k], e_pix);
                        last[k] = e_pix;
                    end
                    if (ncap[k] < 16) begin
                        cap[k][ncap[k]] = po[k];
                        ncap[k]++;
                    end
                end else begin
                    check("pix_hold", k, po[k], last[k]);
                end
            end
        end
    end

    initial begin
        int s0;
        imp_tab[0] = '{1, 1, 15, 16}; imp_tab[1] = '{1, 2, 31, 32}; imp_tab[2] = '{1, 3, 15, 16};
        imp_tab[3] = '{2, 1, 31, 32}; imp_tab[4] = '{2, 2, 63, 64}; imp_tab[5] = '{2, 3, 31, 32};
        imp_tab[6] = '{3, 1, 15, 16}; imp_tab[7] = '{3, 2, 31, 32}; imp_tab[8] = '{3, 3, 15, 16};
        ramp_tab[0] = '{1, 1, 10, 10}; ramp_tab[1] = '{1, 2, 20, 20};
        ramp_tab[2] = '{2, 1, 10, 10}; ramp_tab[3] = '{2, 2, 20, 20};
        for (int k = 0; k < 3; k++) begin
            ncap[k] = 0; strobes[k] = 0; en[k] = 1'b0;
        end
        vin = 1'b0;
        pin = 8'h00;

        do_reset();

        // In IDLE, valid pixels must be ignored
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom));

        // Flat 64x64 frame
        en[0] = 1'b1;
        step(1'b0, 8'h00);
        s0 = strobes[0];
        for (int i = 0; i < 4096; i++) step(1'b1, 8'd100);
        en[0] = 1'b0;
        step(1'b0, 8'h00);
        check("flat_strobes", 0, strobes[0] - s0, 3844);
        check("flat_last_pix", 0, po[0], 100);

        // 5x5 impulse
        en[1] = 1'b1;
        step(1'b0, 8'h00);
        ncap[1] = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                step(1'b1, (r == 2 && c == 2) ? 8'd255 : 8'd0);
        en[1] = 1'b0;
        step(1'b0, 8'h00);
        check("imp_strobes", 1, ncap[1], 9);
        for (int i = 0; i < 9; i++) begin
`ifdef GAUSS_ROUND_EN
            check("imp_val", i, cap[1][i], imp_tab[i].exp_r);
`else
            check("imp_val", i, cap[1][i], imp_tab[i].exp_t);
`endif
        end

        // 4x4 ramp with in_valid toggling
        en[2] = 1'b1;
        step(1'b0, 8'h00);
        ncap[2] = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 8'(c * 10));
                step(1'b0, 8'hAA);
            end
        en[2] = 1'b0;
        step(1'b0, 8'h00);
        check("ramp_strobes", 2, ncap[2], 4);
        for (int i = 0; i < 4; i++) check("ramp_val", i, cap[2][i], ramp_tab[i].exp_t);

        // Abort after 20 inputs, then a full random frame with gaps
        en[0] = 1'b1;
        step(1'b0, 8'h00);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom));
        en[0] = 1'b0;
        step(1'b0, 8'h00);
        check("abort_busy", 0, bz[0], 0);
        en[0] = 1'b1;
        step(1'b0, 8'h00);
        s0 = strobes[0];
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 7) == 0) step(1'b0, 8'($urandom));
            step(1'b1, 8'($urandom));
        end
        en[0] = 1'b0;
        step(1'b0, 8'h00);
        check("restart_strobes", 0, strobes[0] - s0, 3844);

        // Reset mid-frame with in_valid high
        en[0] = 1'b1;
        step(1'b0, 8'h00);
        for (int i = 0; i < 3 * 64 + 10; i++) step(1'b1, 8'd100);
        check("pre_reset_pix", 0, po[0], 100);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom));

        for (int k = 0; k < 3; k++) check("scoreboard_empty", k, qsize(k), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
